rename_iq: RTL and testbench

Decoded-instruction input queue directly upstream of the register-renaming stage. It accepts one decoded instruction per cycle from decode via a valid/ready handshake. It buffers up to `DEPTH` entries and presents the head entry to renaming as `l_dst`/`l_dst_valid`/`inst_en`. It honours renaming's `stall` and the recovery signals (`rec_en`, `rec_busy`), flushing all buffered wrong-path instructions on recovery.

---
 rtl/util_pkg.sv | 20 ++
 rtl/rename_iq_fifo.sv | 72 +++++++
 rtl/rename_iq.sv | 73 +++++++
 tb/tb_rename_iq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/util_pkg.sv
// ============================================================================
// Module      : util_pkg
// Description : Shared constants and types for the rename front-end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package util_pkg;

   localparam int L_REGISTERS = 32;
   localparam int IQ_DEPTH    = 4;

   typedef struct packed {
      logic [$clog2(L_REGISTERS)-1:0] l_dst;
      logic                           l_dst_valid;
   } iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/rename_iq_fifo.sv
// ============================================================================
// Module      : iq_fifo
// Description : Generic circular FIFO with synchronous flush and head read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module iq_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty
);

   localparam int C_PW = $clog2(DEPTH);
   localparam int C_CW = C_PW + 1;
   localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [C_PW-1:0]  r_head;
   logic [C_PW-1:0]  r_tail;
   logic [C_CW-1:0]  r_count;

   logic w_do_push;
   logic w_do_pop;

   assign full      = (r_count == C_FULL);
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign count     = r_count;
   assign head_data = r_mem[r_head];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_mem   <= '{default: '0};
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_tail] <= push_data;
            r_tail        <= r_tail + 1'b1;
         end
         if (w_do_pop) begin
            r_head <= r_head + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/rename_iq.sv
// ============================================================================
// Module      : rename_iq
// Description : Decoded-instruction queue feeding the register-rename stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rename_iq
   import util_pkg::*;
#(
   parameter int L_REGISTERS = util_pkg::L_REGISTERS,
   parameter int DEPTH       = util_pkg::IQ_DEPTH,
   parameter int LW          = $clog2(L_REGISTERS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LW-1:0]          in_l_dst,
   input  logic                   in_l_dst_valid,
   input  logic                   stall,
   input  logic                   rec_en,
   input  logic                   rec_busy,
   output logic [LW-1:0]          l_dst,
   output logic                   l_dst_valid,
   output logic                   inst_en,
   output logic [$clog2(DEPTH):0] count,
   output logic [31:0]            issued_cnt_dbg
);

   logic [LW:0]  w_head;
   logic         w_full;
   logic         w_empty;
   logic         w_push;
   logic [31:0]  r_issued_cnt;

   // Readiness comes from registered occupancy only, so a same-cycle pop
   // never opens a slot for a push.
   assign in_ready = !w_full;
   assign w_push   = in_valid && in_ready && !rec_en;
   assign inst_en  = !w_empty && !stall && !rec_busy && !rec_en;

   assign l_dst          = inst_en ? w_head[LW:1] : '0;
   assign l_dst_valid    = inst_en ? w_head[0]    : 1'b0;
   assign issued_cnt_dbg = r_issued_cnt;

   iq_fifo #(
      .WIDTH (LW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data ({in_l_dst, in_l_dst_valid}),
      .pop       (inst_en),
      .flush     (rec_en),
      .count     (count),
      .head_data (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issued_cnt <= '0;
      end else if (inst_en) begin
         r_issued_cnt <= r_issued_cnt + 32'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rename_iq.sv
// ============================================================================
// Module      : tb_rename_iq
// Description : Self-checking bench for rename_iq with a queue-based model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rename_iq;

   localparam int DEPTH = 4;
   localparam int LW    = 5;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [LW-1:0] in_l_dst = '0;
   logic          in_l_dst_valid = 1'b0;
   logic          stall = 1'b0;
   logic          rec_en = 1'b0;
   logic          rec_busy = 1'b0;
   logic [LW-1:0] l_dst;
   logic          l_dst_valid;
   logic          inst_en;
   logic [CW-1:0] count;
   logic [31:0]   issued_cnt_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [LW:0]   m_q[$];
   logic [31:0]   m_issued = '0;
   logic [LW-1:0] iss_log[$];

   rename_iq #(.L_REGISTERS(32), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_l_dst       (in_l_dst),
      .in_l_dst_valid (in_l_dst_valid),
      .stall          (stall),
      .rec_en         (rec_en),
      .rec_busy       (rec_busy),
      .l_dst          (l_dst),
      .l_dst_valid    (l_dst_valid),
      .inst_en        (inst_en),
      .count          (count),
      .issued_cnt_dbg (issued_cnt_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: outputs follow from queue occupancy and the current inputs;
   // state advances to what the coming rising edge must produce.
   always @(negedge clk) begin
      logic          e_ready;
      logic          e_en;
      logic [LW-1:0] e_ldst;
      logic          e_ldv;
      if (!rst_n) begin
         m_q.delete();
         m_issued = '0;
         chk("rst_count", 32'(count), 0);
         chk("rst_ready", 32'(in_ready), 1);
         chk("rst_inst_en", 32'(inst_en), 0);
         chk("rst_l_dst", 32'(l_dst), 0);
         chk("rst_issued", issued_cnt_dbg, 0);
      end else begin
         e_ready = (m_q.size() != DEPTH);
         e_en    = (m_q.size() != 0) && !stall && !rec_busy && !rec_en;
         e_ldst  = e_en ? m_q[0][LW:1] : '0;
         e_ldv   = e_en ? m_q[0][0] : 1'b0;
         chk("count", 32'(count), 32'(m_q.size()));
         chk("in_ready", 32'(in_ready), 32'(e_ready));
         chk("inst_en", 32'(inst_en), 32'(e_en));
         chk("l_dst", 32'(l_dst), 32'(e_ldst));
         chk("l_dst_valid", 32'(l_dst_valid), 32'(e_ldv));
         chk("issued_cnt", issued_cnt_dbg, m_issued);
         if (e_en) iss_log.push_back(e_ldst);
         if (rec_en) begin
            m_q.delete();
         end else begin
            if (e_en) begin
               void'(m_q.pop_front());
               m_issued = m_issued + 1;
            end
            if (in_valid && e_ready) m_q.push_back({in_l_dst, in_l_dst_valid});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Decode holds the instruction until accepted; bounded wait.
   task automatic push(input logic [LW-1:0] d, input logic v);
      bit done = 0;
      in_valid = 1'b1;
      in_l_dst = d;
      in_l_dst_valid = v;
      for (int i = 0; i < 50 && !done; i++) begin
         if (in_ready) done = 1;
         cyc();
      end
      in_valid = 1'b0;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();

      // In-order issue one cycle after each push
      iss_log.delete();
      push(5'd3, 1'b1);
      chk("t1_en_a", 32'(inst_en), 1);
      chk("t1_ldst_a", 32'(l_dst), 3);
      push(5'd5, 1'b1);
      chk("t1_ldst_b", 32'(l_dst), 5);
      push(5'd7, 1'b1);
      chk("t1_ldst_c", 32'(l_dst), 7);
      idle(2);
      chk("t1_issued", issued_cnt_dbg, 3);
      chk("t1_empty_en", 32'(inst_en), 0);

      // Fill under stall, fifth held by decode
      iss_log.delete();
      stall = 1'b1;
      for (int i = 0; i < 4; i++) push(5'(10 + i), 1'b1);
      chk("t2_count_full", 32'(count), 4);
      chk("t2_ready_low", 32'(in_ready), 0);
      in_valid = 1'b1;
      in_l_dst = 5'd14;
      cyc();
      cyc();
      chk("t2_still_full", 32'(count), 4);
      stall = 1'b0;
      push(5'd14, 1'b1);
      idle(6);
      chk("t2_log_len", 32'(iss_log.size()), 5);
      for (int i = 0; i < 5 && i < iss_log.size(); i++)
         chk("t2_order", 32'(iss_log[i]), 32'(10 + i));

      // Recovery flush drops the concurrent push
      stall = 1'b1;
      push(5'd20, 1'b1);
      push(5'd21, 1'b1);
      in_valid = 1'b1;
      in_l_dst = 5'd22;
      rec_en = 1'b1;
      cyc();
      rec_en = 1'b0;
      in_valid = 1'b0;
      stall = 1'b0;
      #1;
      chk("t3_count", 32'(count), 0);
      chk("t3_inst_en", 32'(inst_en), 0);
      idle(2);

      // rec_busy holds issue but accepts pushes
      rec_busy = 1'b1;
      push(5'd30, 1'b1);
      push(5'd31, 1'b1);
      cyc();
      chk("t4_count", 32'(count), 2);
      chk("t4_inst_en", 32'(inst_en), 0);
      rec_busy = 1'b0;
      #1;
      chk("t4_resume_en", 32'(inst_en), 1);
      chk("t4_resume_ldst", 32'(l_dst), 30);
      idle(3);

      // No-destination instruction keeps its register number
      push(5'd9, 1'b0);
      chk("t5_en", 32'(inst_en), 1);
      chk("t5_ldst", 32'(l_dst), 9);
      chk("t5_ldv", 32'(l_dst_valid), 0);
      cyc();
      chk("t5_idle_ldst", 32'(l_dst), 0);

      // Mid-run reset discards entries at once
      stall = 1'b1;
      push(5'd1, 1'b1);
      push(5'd2, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_count", 32'(count), 0);
      stall = 1'b0;
      cyc();
      rst_n = 1'b1;

      // Back-to-back stream wraps the pointers
      iss_log.delete();
      for (int i = 0; i < 10; i++) begin
         push(5'(40 - 32 + i), 1'b1);
         chk("t7_count_le1", 32'(count <= 1), 1);
      end
      idle(2);
      chk("t7_issued", issued_cnt_dbg, 10);
      chk("t7_log_len", 32'(iss_log.size()), 10);
      for (int i = 0; i < 10 && i < iss_log.size(); i++)
         chk("t7_order", 32'(iss_log[i]), 32'(8 + i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
